id_issue_buffer: RTL and testbench
==================================

// Module: id_issue_buffer
// PURPOSE
//  Parametrised decode-to-issue buffer. Successor of the fixed two-slot ID->issue pipeline register.
//  Holds up to DEPTH bundles, each LANES instructions wide, with per-lane valid bits.
//  Uses a valid/ready handshake and supports flush. Sits between the decoder and the issue/regfile stage.
//  Decouples decode stalls from issue stalls: a stall no longer costs a bubble as it did with a single register.
// PARAMETERS
//  LANES      2   instructions per bundle (issue width)
//  DEPTH      4   bundle entries; any value >= 2, need not be a power of 2
//  PAYLOAD_W  160 bits per lane: pc, inst, uop, imm, rd/rj/rk, excp and flag fields, packed by the decoder
//  CNT_W      $clog2(DEPTH+1)  occupancy counter width (derived)
// PORTS
//  aclk         in   1                clock
//  aresetn      in   1                async reset, active low
//  flush        in   1                sync pipeline flush (exception/branch redirect)
//  in_valid     in   1                decoder offers a bundle
//  in_ready     out  1                buffer accepts bundle this cycle
//  in_lane_vld  in   LANES            per-lane valid of offered bundle
//  in_payload   in   LANES*PAYLOAD_W  lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//  out_valid    out  1                head bundle available
//  out_ready    in   1                issue stage consumes head bundle
//  out_lane_vld out  LANES            per-lane valid of head bundle
//  out_payload  out  LANES*PAYLOAD_W  head bundle; lanes with vld=0 read all-zero
//  count        out  CNT_W            bundles currently stored
// BEHAVIOUR
//  - Reset (aresetn=0, async): wr_ptr=rd_ptr=0, count=0, all entry lane-valids cleared.
//    out_valid=0, out_lane_vld=0, out_payload=0, in_ready=1. Storage data need not be reset.
//  - Enqueue: in_valid & in_ready & |in_lane_vld -> write mem[wr_ptr] and wr_ptr++.
//    A bundle with in_lane_vld==0 is accepted but discarded (no write, count unchanged).
//  - in_ready = (count != DEPTH). No combinational path from out_ready.
//  - Dequeue: out_valid & out_ready -> rd_ptr++.
//  - out_valid = (count != 0). out_lane_vld and out_payload come from mem[rd_ptr].
//    Invalid lanes are forced to zero in out_payload.
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//    When full, no enqueue can occur (in_ready=0), even if out_ready=1.
//  - Pointers wrap DEPTH-1 -> 0 explicitly. count never exceeds DEPTH and never underflows.
//  - Latency: a bundle accepted in cycle N appears at the output in cycle N+1 at the earliest.
//    Bundles leave strictly in FIFO order; lanes within a bundle keep their positions.
//  - flush (sync) has top priority: pointers and count go to 0 and entry valids are cleared at the next edge.
//    An enqueue or dequeue in the same cycle as flush is dropped.
//    in_ready stays driven by the pre-flush count during the flush cycle.
//  - Reset asserted mid-operation discards all contents immediately (async).
// CONFIGURATION
//  ISSUE_BYPASS_EN defined:
//   - When count==0 & in_valid & |in_lane_vld & ~flush, the input bundle is driven straight to the output
//     (out_valid=1, zero latency).
//   - If out_ready=1 in that cycle, the bundle is consumed and not stored.
//     If out_ready=0, it is stored normally.
//  ISSUE_BYPASS_EN undefined:
//   - No bypass; minimum latency is 1 cycle; outputs depend only on registered state.
// TESTING
//  1 Reset: hold aresetn=0 -> out_valid=0, count=0, in_ready=1; release, idle 3 cycles -> unchanged.
//  2 Fill: out_ready=0, push 4 bundles with lane_vld=2'b11 and pc0=0x1c000000+16k
//    -> count=4, in_ready=0; 5th bundle is not accepted.
//  3 Drain in order: from full, out_ready=1 for 4 cycles
//    -> out pc0 = 0x1c000000, ...10, ...20, ...30, then out_valid=0; wrap exercised by a second fill/drain.
//  4 Concurrent: count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, order preserved.
//  5 Partial/empty bundles: push lane_vld=2'b01 -> out_lane_vld=01 and lane1 payload reads 0.
//    Push lane_vld=00 -> accepted, count unchanged.
//  6 Flush: count=3, assert flush together with in_valid and out_ready
//    -> next cycle count=0, out_valid=0, the incoming bundle is lost.
//    With ISSUE_BYPASS_EN: empty buffer, in_valid & out_ready -> out_valid the same cycle and count stays 0.

Source files
------------

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: decode-to-issue bundle FIFO.
//   Holds up to DEPTH bundles of LANES instructions, each lane carrying a
//   PAYLOAD_W-bit decoded record plus a valid bit. Valid/ready on both sides,
//   synchronous flush with top priority, async active-low reset.
//
// Optional build macro: ISSUE_BYPASS_EN
//   When defined, an incoming bundle is presented on the output in the same
//   cycle if the buffer is empty; it is stored only if the issue stage does
//   not take it immediately.
//
// Ports
//   aclk, aresetn          clock, async reset (active low)
//   flush                  sync flush: empties the buffer, drops same-cycle traffic
//   in_valid / in_ready    decoder handshake; in_ready = not full
//   in_lane_vld/in_payload offered bundle, lane i at [i*PAYLOAD_W +: PAYLOAD_W]
//   out_valid / out_ready  issue handshake; out_valid = not empty (or bypass)
//   out_lane_vld/out_payload head bundle, invalid lanes read as zero
//   count                  number of stored bundles
module id_issue_buffer #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 160,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             in_lane_vld,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_lane_vld,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  output logic [CNT_W-1:0]             count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BUN_W = LANES * PAYLOAD_W;

  logic [BUN_W-1:0] r_mem [DEPTH];
  logic [LANES-1:0] r_vld [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_has_lanes;
  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_enq;
  logic             w_deq;
  logic [LANES-1:0] w_sel_vld;
  logic [BUN_W-1:0] w_sel_data;

  assign w_has_lanes = |in_lane_vld;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));

`ifdef ISSUE_BYPASS_EN
  assign w_bypass = w_empty & in_valid & w_has_lanes & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bundle with no valid lanes is accepted on the handshake but never stored.
  // A bypassed bundle taken by issue in the same cycle is not stored either.
  assign w_enq = in_valid & ~w_full & w_has_lanes & ~flush & ~(w_bypass & out_ready);
  assign w_deq = ~w_empty & out_ready & ~flush;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_deq) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Per-entry lane valids; cleared on dequeue so a stale entry never looks live.
  // Enqueue and dequeue never target the same slot (full blocks enqueue, empty blocks dequeue).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_vld[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) r_vld[i] <= '0;
    end else begin
      if (w_deq) r_vld[r_rd_ptr] <= '0;
      if (w_enq) r_vld[r_wr_ptr] <= in_lane_vld;
    end
  end

  // Payload storage; left unreset, invalid lanes are masked on the way out.
  always_ff @(posedge aclk) begin
    if (w_enq) r_mem[r_wr_ptr] <= in_payload;
  end

  // Head selection: stored head, or the incoming bundle when bypassing.
  always_comb begin
    w_sel_vld  = w_empty ? '0 : r_vld[r_rd_ptr];
    w_sel_data = r_mem[r_rd_ptr];
    if (w_bypass) begin
      w_sel_vld  = in_lane_vld;
      w_sel_data = in_payload;
    end
  end

  // Zero the payload of lanes that are not valid.
  always_comb begin
    out_payload = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (w_sel_vld[i]) out_payload[i*PAYLOAD_W +: PAYLOAD_W] = w_sel_data[i*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign out_lane_vld = w_sel_vld;
  assign out_valid    = ~w_empty | w_bypass;
  assign in_ready     = ~w_full;
  assign count        = r_count;

endmodule

// File: tb/tb_id_issue_buffer.sv
module tb_id_issue_buffer;

  localparam int unsigned LANES     = 2;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PAYLOAD_W = 160;
  localparam int unsigned BW        = LANES * PAYLOAD_W;
  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

  typedef struct {
    logic [LANES-1:0] vld;
    logic [BW-1:0]    data;
  } item_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LANES-1:0]  in_lane_vld = '0;
  logic [BW-1:0]     in_payload = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LANES-1:0]  out_lane_vld;
  logic [BW-1:0]     out_payload;
  logic [CNT_W-1:0]  count;

  always #5 aclk = ~aclk;

  id_issue_buffer #(.LANES(LANES), .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_payload(out_payload),
    .count(count)
  );

  // Reference model: queue of stored bundles (front = head).
  item_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;
  bit    pend_push = 1'b0;
  bit    pend_flush = 1'b0;
  item_t pend_item;
  bit    byp_valid = 1'b0;
  item_t byp_item;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mask(input logic [LANES-1:0] v, input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++)
      if (v[i]) r[i*PAYLOAD_W +: PAYLOAD_W] = d[i*PAYLOAD_W +: PAYLOAD_W];
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd_pl();
    logic [BW-1:0] r;
    for (int i = 0; i < int'(BW / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [BW-1:0] pc_pl(input int k);
    logic [BW-1:0] r;
    r = '0;
    r[31:0] = 32'h1c00_0000 + 32'(16 * k);
    r[PAYLOAD_W +: 32] = 32'h1c00_0004 + 32'(16 * k);
    return r;
  endfunction

  // One cycle of stimulus: commit last cycle's model effect at the edge, then
  // drive new inputs and predict whether they will be stored.
  task automatic step(input logic v, input logic [LANES-1:0] lv, input logic [BW-1:0] pl,
                      input logic ordy, input logic fl);
    @(posedge aclk);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    #1;
    in_valid = v; in_lane_vld = lv; in_payload = pl; out_ready = ordy; flush = fl;
    pend_flush = fl;
    pend_push = 1'b0;
    byp_valid = 1'b0;
    if (v && !fl && lv != '0 && exp_q.size() != DEPTH) begin
      pend_item.vld  = lv;
      pend_item.data = mask(lv, pl);
      pend_push = 1'b1;
`ifdef ISSUE_BYPASS_EN
      if (exp_q.size() == 0) begin
        byp_valid = 1'b1;
        byp_item  = pend_item;
        if (ordy) pend_push = 1'b0;
      end
`endif
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0);
  endtask

  // Monitor: compares DUT outputs with the model head and retires on handshake.
  always @(negedge aclk) begin : mon
    int    n;
    bit    ov;
    item_t h;
    if (mon_en) begin
      n  = exp_q.size();
      ov = (n != 0) || byp_valid;
      chk("count", BW'(count), BW'(n));
      chk("in_ready", BW'(in_ready), BW'(n != int'(DEPTH)));
      chk("out_valid", BW'(out_valid), BW'(ov));
      if (ov) begin
        h = (n != 0) ? exp_q[0] : byp_item;
        chk("out_lane_vld", BW'(out_lane_vld), BW'(h.vld));
        chk("out_payload", out_payload, h.data);
        if (out_ready && !flush && n != 0) void'(exp_q.pop_front());
      end else begin
        chk("idle_lane_vld", BW'(out_lane_vld), '0);
        chk("idle_payload", out_payload, '0);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    chk("rst_out_valid", BW'(out_valid), '0);
    chk("rst_count", BW'(count), '0);
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_payload", out_payload, '0);
    aresetn = 1'b1;
    #1 mon_en = 1'b1;
    repeat (3) idle(1'b0);

    // Fill then drain, twice so both pointers wrap
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 2'b11, pc_pl(k), 1'b0, 1'b0);
      step(1'b1, 2'b11, pc_pl(9), 1'b0, 1'b0);
      chk("fill_count", BW'(count), BW'(4));
      chk("fill_in_ready", BW'(in_ready), '0);
      for (int k = 0; k < 4; k++) begin
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_pc0", BW'(out_payload[31:0]), BW'(32'h1c00_0000 + 32'(16 * k)));
      end
      idle(1'b0);
      chk("drain_empty", BW'(out_valid), '0);
    end

    // Concurrent push/pop at count=2
    step(1'b1, 2'b11, rnd_pl(), 1'b0, 1'b0);
    step(1'b1, 2'b11, rnd_pl(), 1'b0, 1'b0);
    idle(1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 2'b11, rnd_pl(), 1'b1, 1'b0);
    idle(1'b0);
    chk("concurrent_count", BW'(count), BW'(2));
    repeat (3) idle(1'b1);

    // Partial and empty bundles
    step(1'b1, 2'b01, rnd_pl(), 1'b0, 1'b0);
    idle(1'b0);
    chk("partial_lane_vld", BW'(out_lane_vld), BW'(2'b01));
    chk("partial_lane1_zero", BW'(out_payload[PAYLOAD_W +: PAYLOAD_W]), '0);
    step(1'b1, 2'b00, rnd_pl(), 1'b0, 1'b0);
    idle(1'b0);
    chk("empty_bundle_count", BW'(count), BW'(1));
    repeat (2) idle(1'b1);

    // Flush with concurrent enqueue/dequeue
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, rnd_pl(), 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 2'b11, rnd_pl(), 1'b1, 1'b1);
    idle(1'b0);
    chk("flush_count", BW'(count), '0);
    chk("flush_out_valid", BW'(out_valid), '0);

`ifdef ISSUE_BYPASS_EN
    step(1'b1, 2'b11, rnd_pl(), 1'b1, 1'b0);
    chk("bypass_out_valid", BW'(out_valid), BW'(1));
    idle(1'b0);
    chk("bypass_count", BW'(count), '0);
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++)
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), rnd_pl(),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 31) == 0));

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) step(1'b1, 2'b11, rnd_pl(), 1'b0, 1'b0);
    mon_en = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    chk("async_rst_count", BW'(count), '0);
    chk("async_rst_out_valid", BW'(out_valid), '0);
    chk("async_rst_in_ready", BW'(in_ready), BW'(1));
    exp_q.delete();
    pend_push = 1'b0; pend_flush = 1'b0; byp_valid = 1'b0;
    in_valid = 1'b0; in_lane_vld = '0; out_ready = 1'b0; flush = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1 mon_en = 1'b1;
    for (int c = 0; c < 200; c++)
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), rnd_pl(),
           ($urandom_range(0, 2) != 0), 1'b0);
    repeat (6) idle(1'b1);

    @(posedge aclk);
    #1 mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
